// File: rtl/clk_div_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : clk_div_pkg                                                      |
// | Desc    : Shared sizing helpers and reset divisors for the clock divider.  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package clk_div_pkg;

    // Channel index width; never zero, even for a single channel.
    function automatic int ch_w(input int num_ch);
        return (num_ch <= 1) ? 1 : $clog2(num_ch);
    endfunction

    // Reset divisor of channel i: 2, 4, 8, 16, ...
    function automatic int unsigned default_div(input int i);
        return 32'd1 << (i + 1);
    endfunction

    function automatic bit cfg_ok(input int num_ch, input int cnt_w);
        return (num_ch >= 1) && (num_ch <= 16) && (cnt_w >= num_ch + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_chan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : clk_div_chan                                                     |
// | Desc    : One divider channel: divisor, free-running counter, wave, tick.  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module clk_div_chan #(
    parameter int              CNT_W       = 8,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_ena,
    input  logic             i_sync,
    input  logic             i_cfg_wr,
    input  logic [CNT_W-1:0] i_cfg_div,
    output logic             o_div_out,
    output logic             o_tick
);

    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_cnt;
    logic             r_div_out;
    logic             r_tick;
    logic             w_last;
    logic [CNT_W-1:0] w_high_len;

    assign w_last     = (r_cnt == r_div - CNT_W'(1));
    // ceil(D/2): odd divisors get the extra cycle in the high phase
    assign w_high_len = r_div - (r_div >> 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div     <= DEFAULT_DIV;
            r_cnt     <= '0;
            r_div_out <= 1'b0;
            r_tick    <= 1'b0;
        end else if (i_cfg_wr) begin
            r_div     <= i_cfg_div;
            r_cnt     <= '0;
            r_div_out <= 1'b0;
            r_tick    <= 1'b0;
        end else if (i_sync) begin
            r_cnt     <= '0;
            r_div_out <= 1'b0;
            r_tick    <= 1'b0;
        end else if (!i_ena) begin
            r_tick    <= 1'b0;
        end else if (r_div == '0) begin
            r_cnt     <= '0;
            r_div_out <= 1'b0;
            r_tick    <= 1'b0;
        end else if (r_div == CNT_W'(1)) begin
            r_cnt     <= '0;
            r_div_out <= 1'b1;
            r_tick    <= 1'b1;
        end else begin
            r_div_out <= (r_cnt < w_high_len);
            r_tick    <= w_last;
            r_cnt     <= w_last ? '0 : r_cnt + CNT_W'(1);
        end
    end

    assign o_div_out = r_div_out;
    assign o_tick    = r_tick;

endmodule
`default_nettype wire

// File: rtl/clk_div_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : clk_div_bank                                                     |
// | Desc    : Bank of programmable clock-enable dividers with masked AND out.  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int CNT_W  = 8,
    localparam int CH_W   = ch_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ena,
    input  logic              sync,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [NUM_CH-1:0] and_mask,
    output logic [NUM_CH-1:0] div_out,
    output logic [NUM_CH-1:0] tick,
    output logic              and_out
);

    logic [NUM_CH-1:0] w_cfg_wr;

    if (!cfg_ok(NUM_CH, CNT_W)) begin : g_bad_cfg
        $error("clk_div_bank: NUM_CH must be 1..16 and CNT_W >= NUM_CH+1");
    end

    // Out-of-range channel indices match no channel, so such writes are dropped.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        assign w_cfg_wr[i] = cfg_we && (cfg_ch == CH_W'(i));

        clk_div_chan #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (CNT_W'(default_div(i)))
        ) u_chan (
            .clk       (clk),
            .rst       (reset),
            .i_ena     (ena),
            .i_sync    (sync),
            .i_cfg_wr  (w_cfg_wr[i]),
            .i_cfg_div (cfg_div),
            .o_div_out (div_out[i]),
            .o_tick    (tick[i])
        );
    end

    assign and_out = (|and_mask) & (&(div_out | ~and_mask));

endmodule
`default_nettype wire

// File: tb/tb_clk_div_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_clk_div_bank                                                  |
// | Desc    : Directed self-checking bench for clk_div_bank.                   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_clk_div_bank;

    logic       clk = 1'b0;
    logic       reset, ena, sync, cfg_we, cfg_we3;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_div;
    logic [3:0] and_mask, div_out, tick;
    logic       and_out;
    logic [2:0] and_mask3, div_out3, tick3;
    logic       and_out3;

    int n_assert = 0;
    int n_fail   = 0;
    int p        = 0;
    int q        = 0;

    // Index j = outputs after the (j+1)-th edge from phase 0 with divisors 2/4/8/16.
    logic [3:0] exp_div  [16];
    logic [3:0] exp_tick [16];
    logic       c2o      [3];
    logic       c2t      [3];

    clk_div_bank #(.NUM_CH(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .ena(ena), .sync(sync), .cfg_we(cfg_we),
        .cfg_ch(cfg_ch), .cfg_div(cfg_div), .and_mask(and_mask),
        .div_out(div_out), .tick(tick), .and_out(and_out)
    );

    // Three-channel copy: lets channel index 3 be out of range.
    clk_div_bank #(.NUM_CH(3), .CNT_W(8)) dut3 (
        .clk(clk), .reset(reset), .ena(ena), .sync(sync), .cfg_we(cfg_we3),
        .cfg_ch(cfg_ch), .cfg_div(cfg_div), .and_mask(and_mask3),
        .div_out(div_out3), .tick(tick3), .and_out(and_out3)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_state(input string tag, input logic [3:0] ed, input logic [3:0] et);
        logic exp_and;
        exp_and = (and_mask != 4'b0) && ((ed & and_mask) == and_mask);
        check({tag, " div_out"}, div_out, ed);
        check({tag, " tick"}, tick, et);
        check({tag, " and_out"}, {3'b0, and_out}, {3'b0, exp_and});
    endtask

    // c0_mode: 0 table, 1 forced 0/0, 2 forced 1/1. c2_mode: 0 table, 1 restart edge, 2 div-3 pattern.
    task automatic step_tbl(input string tag, input int c0_mode, input int c2_mode);
        logic [3:0] ed, et;
        ed = exp_div[p];
        et = exp_tick[p];
        if (c0_mode == 1) begin ed[0] = 1'b0; et[0] = 1'b0; end
        if (c0_mode == 2) begin ed[0] = 1'b1; et[0] = 1'b1; end
        if (c2_mode == 1) begin ed[2] = 1'b0; et[2] = 1'b0; end
        if (c2_mode == 2) begin ed[2] = c2o[q]; et[2] = c2t[q]; end
        step();
        expect_state(tag, ed, et);
        if (c0_mode == 0 && c2_mode == 0) begin
            check({tag, " dut3 div_out"}, {1'b0, div_out3}, {1'b0, ed[2:0]});
            check({tag, " dut3 tick"}, {1'b0, tick3}, {1'b0, et[2:0]});
            check({tag, " dut3 and_out"}, {3'b0, and_out3}, {3'b0, &ed[2:0]});
        end
        p = (p + 1) % 16;
        if (c2_mode == 1) q = 0;
        if (c2_mode == 2) q = (q + 1) % 3;
    endtask

    initial begin
        exp_div  = '{4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8,
                     4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1, 4'h0};
        exp_tick = '{4'h0, 4'h1, 4'h0, 4'h3, 4'h0, 4'h1, 4'h0, 4'h7,
                     4'h0, 4'h1, 4'h0, 4'h3, 4'h0, 4'h1, 4'h0, 4'hF};
        c2o = '{1'b1, 1'b1, 1'b0};
        c2t = '{1'b0, 1'b0, 1'b1};

        reset = 1'b1; ena = 1'b0; sync = 1'b0; cfg_we = 1'b0; cfg_we3 = 1'b0;
        cfg_ch = 2'd0; cfg_div = 8'd0; and_mask = 4'b0101; and_mask3 = 3'b111;
        step();
        step();
        expect_state("reset", 4'h0, 4'h0);
        check("reset dut3 div_out", {1'b0, div_out3}, 4'h0);

        reset = 1'b0; ena = 1'b1; p = 0;
        for (int i = 0; i < 16; i++) step_tbl("default", 0, 0);

        // Write to channel 3 of the 3-channel copy must change nothing.
        cfg_we3 = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd0;
        step_tbl("oob write", 0, 0);
        cfg_we3 = 1'b0;
        for (int i = 0; i < 3; i++) step_tbl("oob after", 0, 0);

        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            expect_state("ena low", exp_div[(p + 15) % 16], 4'h0);
        end
        ena = 1'b1;
        for (int i = 0; i < 6; i++) step_tbl("ena resume", 0, 0);

        cfg_we = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd3;
        step_tbl("ch2 write", 0, 1);
        cfg_we = 1'b0;
        for (int i = 0; i < 6; i++) step_tbl("ch2 div3", 0, 2);

        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd0;
        step_tbl("ch0 write0", 1, 2);
        cfg_we = 1'b0;
        for (int i = 0; i < 3; i++) step_tbl("ch0 div0", 1, 2);

        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd1;
        step_tbl("ch0 write1", 1, 2);
        cfg_we = 1'b0;
        for (int i = 0; i < 3; i++) step_tbl("ch0 div1", 2, 2);

        // Sync together with a ch0 write: both restart, ch0 keeps div 2.
        sync = 1'b1; cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd2;
        step();
        expect_state("sync edge", 4'h0, 4'h0);
        sync = 1'b0; cfg_we = 1'b0;
        step(); expect_state("sync e1", 4'hF, 4'h0);
        step(); expect_state("sync e2", 4'hE, 4'h1);
        step(); expect_state("sync e3", 4'h9, 4'h4);
        step(); expect_state("sync e4", 4'hC, 4'h3);
        step(); expect_state("sync e5", 4'hF, 4'h0);
        and_mask = 4'b0000;
        step(); expect_state("mask0", 4'hA, 4'h5);
        and_mask = 4'b1000;
        step(); expect_state("mask8", 4'hD, 4'h0);

        and_mask = 4'b0101; reset = 1'b1;
        step();
        expect_state("mid reset", 4'h0, 4'h0);
        reset = 1'b0; p = 0;
        for (int i = 0; i < 16; i++) step_tbl("post reset", 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
